truth_table_scanner: RTL
========================

// Module: truth_table_scanner
// PURPOSE
//  Sequential reader for small combinational functions: sweeps every input code of an
//  external N-input, 1-output function, samples its output and assembles the truth table.
//  Compares the table against an expected table and reports per-entry mismatches.
//  Sits beside exercise logic blocks as an on-chip self-check / table extractor.
// PARAMETERS
//  N_IN    3   number of function inputs; table width W = 2**N_IN (N_IN range 1..4)
//  SETTLE  1   cycles fn_in is held before sampling fn_out (>=1)
// PORTS
//  clk       in   1    single clock, rising edge
//  reset_n   in   1    asynchronous, active-low reset
//  start     in   1    request a scan; accepted only in IDLE
//  expected  in   W    expected table; bit i = f(i); captured when start is accepted
//  fn_in     out  N_IN input code driven to function under test; MSB = first input (a)
//  fn_out    in   1    function output for current fn_in
//  busy      out  1    high from the cycle after start is accepted through the DONE cycle
//  done      out  1    one-cycle pulse, scan complete
//  table_q   out  W    captured table; bit i = fn_out sampled with fn_in == i
//  mismatch  out  W    table_q ^ expected, valid from done
//  pass      out  1    1 when mismatch == 0, valid from done
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; fn_in, busy, done, table_q,
//    mismatch, pass all 0; internal idx and settle count 0.
//  - States: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  - IDLE: start=1 at edge T -> exp_q <= expected, idx <= 0, table_q/mismatch/pass <= 0,
//    go DRIVE. start=0 -> stay; outputs hold last results.
//  - DRIVE: fn_in = idx; stays SETTLE cycles (counter 0..SETTLE-1), then SAMPLE.
//  - SAMPLE: fn_in = idx; at edge table_q[idx] <= fn_out. idx == W-1 -> DONE,
//    else idx <= idx+1, go DRIVE. Each entry costs SETTLE+1 cycles.
//  - DONE (1 cycle): done=1; mismatch <= table_q ^ exp_q, pass <= (table_q == exp_q),
//    registered at exit edge; go IDLE.
//  - Latency: done high in cycle T+1+W*(SETTLE+1) (N_IN=3,SETTLE=1: T+17);
//    mismatch/pass valid the cycle after done and held until next accepted start.
//  - start ignored in DRIVE/SAMPLE/DONE; no queuing; a held-high start restarts a scan
//    only after returning to IDLE (one scan per IDLE cycle with start=1).
//  - idx width N_IN; never wraps: terminal compare on W-1 stops the sweep.
//  - fn_in is 0 in IDLE and DONE.
//  - fn_out sampled as-is (X propagates into table_q; bench must not rely on X).
//  - reset_n low mid-scan: immediate return to IDLE, all outputs 0, partial table lost.
// STRUCTURE
//  - Package tts_pkg: state_t enum {IDLE, DRIVE, SAMPLE, DONE}; localparam helpers for
//    W = 2**N_IN and settle counter width $clog2(SETTLE+1).
//  - Sub-module settle_timer: loadable count-up timer with terminal flag (SETTLE cycles);
//    scanner holds FSM, idx counter, table/compare registers.
// TESTING
//  1 fn = a~b + ~b~c + ~abc (comb), expected=8'h39, start 1 cycle -> table_q=8'h39,
//    pass=1, mismatch=0, done at T+17, fn_in visits 0..7 in order.
//  2 Same fn, expected=8'h38 -> table_q=8'h39, mismatch=8'h01, pass=0.
//  3 start held high 40 cycles -> scans back-to-back, done pulses at T+17 and T+35,
//    start during busy never perturbs idx.
//  4 reset_n low at T+9 -> all outputs 0 same cycle; after release new start with
//    fn = constant 1, expected=8'hFF -> pass=1.
//  5 SETTLE=3, fn registered (1-cycle delay of a^b^c) -> table_q=8'h96, done at T+33;
//    with SETTLE=1 a 2-cycle-delay fn yields mismatch != 0.
//  6 N_IN=2, fn = XNOR, expected=4'h9 -> table_q=4'h9, pass=1, done at T+9.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizing helpers for the truth-table scanner slice.
// Table width and settle-counter width are derived from the block parameters here.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int tts_width(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  function automatic int tts_cnt_width(input int settle);
    return (settle < 32'sd1) ? 32'sd1 : $clog2(settle + 32'sd1);
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Control, result and function-under-test signals of the truth-table scanner.
// The scanner attaches through the slave modport; the requester/harness uses master.
interface truth_table_scanner_if
  import tts_pkg::*;
#(
  parameter int N_IN = 3
) ();

  localparam int W = tts_width(N_IN);

  logic            start;
  logic [W-1:0]    expected;
  logic [N_IN-1:0] fn_in;
  logic            fn_out;
  logic            busy;
  logic            done;
  logic [W-1:0]    table_q;
  logic [W-1:0]    mismatch;
  logic            pass;

  modport master (
    output start, expected, fn_out,
    input  fn_in, busy, done, table_q, mismatch, pass
  );

  modport slave (
    input  start, expected, fn_out,
    output fn_in, busy, done, table_q, mismatch, pass
  );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable count-up timer: counts 0..SETTLE-1 while enabled and flags the last count.
// Loading clears it, so each DRIVE phase starts from zero.
module settle_timer
  import tts_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic term
);

  localparam int            CW   = tts_cnt_width(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_r;

  // settle counter, saturating at the terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
    end else if (en && !term) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = (cnt_r == LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input code of an external N_IN-input function, samples its output into
// table_q and compares the captured table against the expected table given at start.
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  truth_table_scanner_if.slave bus
);

  localparam int              W        = tts_width(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(W - 1);

  state_t          state_r, state_s;
  logic [N_IN-1:0] idx_r, idx_s;
  logic [N_IN-1:0] fn_in_r, fn_in_s;
  logic [W-1:0]    exp_r, table_r, mismatch_r;
  logic            pass_r, busy_r, done_r;
  logic            busy_s, done_s, accept_s;
  logic            term_s, timer_load_s, timer_en_s;

  assign accept_s     = (state_r == IDLE) && bus.start;
  assign timer_en_s   = (state_r == DRIVE);
  assign timer_load_s = (state_r != DRIVE);

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load_s),
    .en     (timer_en_s),
    .term   (term_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next state, next index and next values of the registered status outputs
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = DRIVE;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (term_s) begin
          state_s = SAMPLE;
        end else begin
          state_s = DRIVE;
        end
      end
      SAMPLE: begin
        // terminal compare stops the sweep, so idx never wraps
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = DRIVE;
          idx_s   = idx_r + N_IN'(1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    fn_in_s = ((state_s == DRIVE) || (state_s == SAMPLE)) ? idx_s : '0;
    busy_s  = (state_s != IDLE);
    done_s  = (state_s == DONE);
  end

  // index, table capture, comparison results and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r      <= '0;
      fn_in_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      exp_r      <= '0;
      table_r    <= '0;
      mismatch_r <= '0;
      pass_r     <= 1'b0;
    end else begin
      idx_r   <= idx_s;
      fn_in_r <= fn_in_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (accept_s) begin
        exp_r      <= bus.expected;
        table_r    <= '0;
        mismatch_r <= '0;
        pass_r     <= 1'b0;
      end else if (state_r == SAMPLE) begin
        table_r[idx_r] <= bus.fn_out;
      end else if (state_r == DONE) begin
        mismatch_r <= table_r ^ exp_r;
        pass_r     <= (table_r == exp_r);
      end
    end
  end

  assign bus.fn_in    = fn_in_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.table_q  = table_r;
  assign bus.mismatch = mismatch_r;
  assign bus.pass     = pass_r;

endmodule
